channel_frame_serializer: RTL

//  Consumes the 4-bit channel code produced by the channel encoder stage and sends it as an async serial frame on tx.

---
 rtl/channel_tx_pkg.sv | 6 +
 rtl/channel_frame_serializer_baud_tick_gen.sv | 16 +
 rtl/channel_frame_serializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/channel_tx_pkg.sv
// channel_tx_pkg: shared widths, the "no channel" code and FSM state encoding for the channel serializer
package channel_tx_pkg;
  localparam int CH_W = 4;
  localparam logic [CH_W-1:0] CH_NONE = 4'hF;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/channel_frame_serializer_baud_tick_gen.sv
// baud_tick_gen: bit-period divider; bit_tick on count CLK_DIV-1, count held at 0 while run=0
//   clk, arst (async, active-low), run (enable), bit_tick (end of current bit period)
module baud_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic arst,
  input  logic run,
  output logic bit_tick
);
  logic [15:0] cnt;
  assign bit_tick = run && cnt == 16'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge arst)
    if (!arst) cnt <= '0;
    else cnt <= (!run || bit_tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/channel_frame_serializer.sv
// channel_frame_serializer: sends 4-bit channel codes as async frames (start, data LSB-first, [even parity], stop)
//   clk, arst (async, active-low); in_valid/in_data/in_ready upstream handshake, 4'hF dropped silently
//   tx registered serial line (idle high), busy = not IDLE, frame_done = last clk of final stop bit
//   CHANNEL_TX_PARITY_EN inserts an even-parity bit after the data bits
module channel_frame_serializer
  import channel_tx_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_data,
  output logic            in_ready,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);
  state_t state, nstate;
  logic [2:0] bcnt, nbcnt;
  logic [CH_W-1:0] sh, nsh;
  logic ntx, tick;
  assign busy = state != S_IDLE;
  assign in_ready = state == S_IDLE;
  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_baud (.clk(clk), .arst(arst), .run(busy), .bit_tick(tick));
`ifdef CHANNEL_TX_PARITY_EN
  logic par;
  // parity is captured at acceptance since the shift register is consumed by the time it is sent
  always_ff @(posedge clk or negedge arst)
    if (!arst) par <= 1'b0;
    else if (state == S_IDLE && in_valid) par <= ^in_data;
`endif
  always_comb begin
    nstate = state;
    nbcnt = bcnt;
    nsh = sh;
    ntx = tx;
    frame_done = 1'b0;
    case (state)
      S_IDLE:
        if (in_valid && in_data != CH_NONE) begin
          nstate = S_START;
          nsh = in_data;
          nbcnt = '0;
          ntx = 1'b0;
        end
      S_START:
        if (tick) begin
          nstate = S_DATA;
          ntx = sh[0];
          nsh = sh >> 1;
          nbcnt = '0;
        end
      S_DATA:
        if (tick) begin
          if (bcnt == 3'(CH_W - 1)) begin
            nbcnt = '0;
`ifdef CHANNEL_TX_PARITY_EN
            nstate = S_PARITY;
            ntx = par;
`else
            nstate = S_STOP;
            ntx = 1'b1;
`endif
          end else begin
            nbcnt = bcnt + 3'd1;
            ntx = sh[0];
            nsh = sh >> 1;
          end
        end
      S_PARITY:
        if (tick) begin
          nstate = S_STOP;
          ntx = 1'b1;
          nbcnt = '0;
        end
      S_STOP:
        if (tick) begin
          if (bcnt == 3'(STOP_BITS - 1)) begin
            nstate = S_IDLE;
            frame_done = 1'b1;
          end else nbcnt = bcnt + 3'd1;
          ntx = 1'b1;
        end
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      state <= S_IDLE;
      bcnt <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else begin
      state <= nstate;
      bcnt <= nbcnt;
      sh <= nsh;
      tx <= ntx;
    end
endmodule
